// File: rtl/multi_debounce_if.sv
// -----------------------------------------------------------------------------
// multi_debounce_if
// Bundles the per-channel signals of the multi_debounce block into one
// interface. The debouncer itself takes the slave view; whatever drives the
// raw inputs and consumes the debounced results takes the master view.
//
// Signals (N_CH = channel count):
//   in         [N_CH-1:0]  raw channel inputs
//   edge_mode  [1:0]       00 rise, 01 fall, 10 both, 11 pulses/flags off
//   flag_clr   [N_CH-1:0]  per-channel acknowledge of sticky flags
//   level      [N_CH-1:0]  debounced level per channel
//   pulse      [N_CH-1:0]  one-cycle pulse on a qualified accepted edge
//   flags      [N_CH-1:0]  sticky copy of pulse, held until cleared
//   any_pulse              OR of all channel pulses, same cycle as pulse
// -----------------------------------------------------------------------------
interface multi_debounce_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] in;
    logic [1:0]      edge_mode;
    logic [N_CH-1:0] flag_clr;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] flags;
    logic            any_pulse;

    modport master (
        output in,
        output edge_mode,
        output flag_clr,
        input  level,
        input  pulse,
        input  flags,
        input  any_pulse
    );

    modport slave (
        input  in,
        input  edge_mode,
        input  flag_clr,
        output level,
        output pulse,
        output flags,
        output any_pulse
    );
endinterface

// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
// N_CH independent debouncers sharing one clock. A channel accepts a new level
// only after STABLE_CYCLES consecutive samples that differ from its current
// debounced level; any sample equal to the current level restarts the count.
// Each accepted change can raise a one-cycle pulse (qualified by edge_mode)
// and set a sticky flag that software acknowledges through flag_clr.
//
// Ports:
//   clk     in  clock, all state updates on the rising edge
//   resetn  in  asynchronous active-low reset
//   bus     multi_debounce_if.slave (in, edge_mode, flag_clr -> level, pulse,
//           flags, any_pulse)
//
// Parameters:
//   N_CH           number of channels (>= 1)
//   STABLE_CYCLES  differing samples needed to accept a new level (>= 1)
//   INIT_LEVEL     reset value of every debounced level
//
// Build option:
//   DEBOUNCE_SYNC_EN  when defined, every raw input first passes through a
//                     2-flop synchroniser (reset to INIT_LEVEL), adding two
//                     edges of latency. When undefined, inputs must already
//                     be synchronous to clk.
// -----------------------------------------------------------------------------
module multi_debounce #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 20,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input logic              clk,
    input logic              resetn,
    multi_debounce_if.slave  bus
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [N_CH-1:0]  samp;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  pulse_q;
    logic [N_CH-1:0]  pulse_d;
    logic [N_CH-1:0]  flags_q;
    logic [N_CH-1:0]  flags_d;
    logic             any_pulse_q;

    // Decides whether an accepted change to new_level should produce a pulse.
    function automatic logic qualify(input logic new_level, input logic [1:0] mode);
        logic q;
        case (mode)
            MODE_RISE: q = new_level;
            MODE_FALL: q = ~new_level;
            MODE_BOTH: q = 1'b1;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;

    // Two-stage synchroniser; resetting to INIT_LEVEL keeps the debouncer
    // from seeing a spurious difference right after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= {N_CH{INIT_LEVEL}};
            sync_q2 <= {N_CH{INIT_LEVEL}};
        end else begin
            sync_q1 <= bus.in;
            sync_q2 <= sync_q1;
        end
    end

    assign samp = sync_q2;
`else
    assign samp = bus.in;
`endif

    // Next-state logic for every channel. The counter tracks how many
    // consecutive samples have disagreed with the debounced level; it tops
    // out at CNT_MAX, where the next disagreeing sample is accepted, so it
    // can never wrap. The set term of flags is the same pulse being
    // registered this edge, so a set always wins over a same-cycle clear.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (samp[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = samp[i];
                    pulse_d[i] = qualify(samp[i], bus.edge_mode);
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        flags_d = pulse_d | (flags_q & ~bus.flag_clr);
    end

    // All outputs come straight from these registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q     <= {N_CH{INIT_LEVEL}};
            pulse_q     <= '0;
            flags_q     <= '0;
            any_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            flags_q     <= flags_d;
            any_pulse_q <= |pulse_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.pulse     = pulse_q;
    assign bus.flags     = flags_q;
    assign bus.any_pulse = any_pulse_q;

endmodule

// File: tb/tb_multi_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_debounce
// Directed self-checking bench for multi_debounce with N_CH=4,
// STABLE_CYCLES=20, INIT_LEVEL=0. Expected levels and flags are kept in a
// small bench-side model; expected pulses are written by hand per step.
// When DEBOUNCE_SYNC_EN is defined the expected response is two edges later.
// -----------------------------------------------------------------------------
module tb_multi_debounce;

    localparam int N_CH   = 4;
    localparam int STABLE = 20;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic resetn;

    multi_debounce_if #(.N_CH(N_CH)) bus ();

    multi_debounce #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N_CH-1:0] exp_level;
    logic [N_CH-1:0] exp_flags;

    // One comparison: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advances n rising edges and samples 1 unit after each; the flag model
    // applies any clear that was present at that edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            exp_flags = exp_flags & ~bus.flag_clr;
        end
    endtask

    // Drives a new input vector and holds it: one edge before acceptance the
    // outputs must be unchanged, at the acceptance edge level follows the new
    // inputs and pulse/any_pulse/flags match the hand-computed pulse vector.
    task automatic applyStimulus(input string tag, input logic [N_CH-1:0] new_in,
                                 input logic [N_CH-1:0] exp_pulse);
        bus.in = new_in;
        tick(STABLE - 1 + SYNC_LAT);
        checkOutput({tag, "_pre_level"}, 32'(bus.level), 32'(exp_level));
        checkOutput({tag, "_pre_pulse"}, 32'(bus.pulse), 32'(0));
        tick(1);
        exp_level = new_in;
        exp_flags = exp_flags | exp_pulse;
        checkOutput({tag, "_level"}, 32'(bus.level), 32'(exp_level));
        checkOutput({tag, "_pulse"}, 32'(bus.pulse), 32'(exp_pulse));
        checkOutput({tag, "_any"},   32'(bus.any_pulse), 32'(|exp_pulse));
        checkOutput({tag, "_flags"}, 32'(bus.flags), 32'(exp_flags));
    endtask

    initial begin
        resetn        = 1'b0;
        bus.in        = '0;
        bus.edge_mode = 2'b00;
        bus.flag_clr  = '0;
        exp_level     = '0;
        exp_flags     = '0;

        // Reset state
        #12;
        checkOutput("rst_level", 32'(bus.level), 32'(0));
        checkOutput("rst_pulse", 32'(bus.pulse), 32'(0));
        checkOutput("rst_flags", 32'(bus.flags), 32'(0));
        checkOutput("rst_any",   32'(bus.any_pulse), 32'(0));
        resetn = 1'b1;
        tick(2);

        // Rising edge on channel 0 in rise mode, then pulse drops next cycle
        $display("[TB] rise on channel 0");
        applyStimulus("rise0", 4'b0001, 4'b0001);
        tick(1);
        checkOutput("rise0_pulse_end", 32'(bus.pulse), 32'(0));
        checkOutput("rise0_any_end",   32'(bus.any_pulse), 32'(0));
        checkOutput("rise0_flag_hold", 32'(bus.flags), 32'(exp_flags));

        // Asynchronous reset in the middle of channel 1 counting
        $display("[TB] async reset mid-count");
        bus.in = 4'b0011;
        tick(10);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_level", 32'(bus.level), 32'(0));
        checkOutput("arst_pulse", 32'(bus.pulse), 32'(0));
        checkOutput("arst_flags", 32'(bus.flags), 32'(0));
        checkOutput("arst_any",   32'(bus.any_pulse), 32'(0));
        bus.in    = '0;
        exp_level = '0;
        exp_flags = '0;
        #1;
        resetn = 1'b1;
        tick(3);

        // Glitch: 19 high samples, one low, then a full run of 20
        $display("[TB] glitch on channel 1");
        bus.in = 4'b0010;
        tick(STABLE - 1);
        checkOutput("glitch_19_level", 32'(bus.level), 32'(0));
        checkOutput("glitch_19_pulse", 32'(bus.pulse), 32'(0));
        bus.in = 4'b0000;
        tick(1);
        checkOutput("glitch_low_level", 32'(bus.level), 32'(0));
        checkOutput("glitch_low_pulse", 32'(bus.pulse), 32'(0));
        applyStimulus("glitch_run", 4'b0010, 4'b0010);

        // Edge modes on channel 2
        $display("[TB] edge modes on channel 2");
        bus.edge_mode = 2'b01;
        applyStimulus("fall_mode_rise", 4'b0110, 4'b0000);
        applyStimulus("fall_mode_fall", 4'b0010, 4'b0100);
        bus.edge_mode = 2'b10;
        applyStimulus("both_mode_rise", 4'b0110, 4'b0100);
        applyStimulus("both_mode_fall", 4'b0010, 4'b0100);
        bus.flag_clr = 4'b1111;
        tick(1);
        bus.flag_clr = 4'b0000;
        checkOutput("clear_all_flags", 32'(bus.flags), 32'(exp_flags));
        bus.edge_mode = 2'b11;
        applyStimulus("off_mode_rise", 4'b0110, 4'b0000);
        applyStimulus("off_mode_fall", 4'b0010, 4'b0000);

        // Same-cycle clear loses to the set; a later clear wins
        $display("[TB] flag clear on channel 3");
        bus.edge_mode = 2'b00;
        bus.flag_clr  = 4'b1000;
        applyStimulus("clr_same_cycle", 4'b1010, 4'b1000);
        tick(1);
        checkOutput("clr_next_cycle", 32'(bus.flags), 32'(exp_flags));
        bus.flag_clr = 4'b0000;

        // All four channels change together in both-edge mode
        $display("[TB] all channels toggle");
        bus.edge_mode = 2'b10;
        applyStimulus("multi", 4'b0101, 4'b1111);
        tick(1);
        checkOutput("multi_pulse_end", 32'(bus.pulse), 32'(0));
        checkOutput("multi_any_end",   32'(bus.any_pulse), 32'(0));
        checkOutput("multi_flags",     32'(bus.flags), 32'(exp_flags));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
